botao_pedestre: RTL and testbench

Pedestrian-button conditioner sitting directly upstream of the `semaforo` controller; drives its `bt` input. Synchronises and debounces the raw push-button and latches a single crossing request. Holds the request to `semaforo` until light A is seen red, then applies a re-arm lockout. Isolates the controller from bounce, metastability and repeated presses.

---
 rtl/semaforo_pkg.sv | 20 ++
 rtl/botao_pedestre_debounce.sv | 42 ++++
 rtl/botao_pedestre.sv | 91 +++++++++
 tb/tb_botao_pedestre.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Light encodings shared with semaforo, plus the state codes of the pedestrian-button FSM.
package semaforo_pkg;

  localparam logic [2:0] LUZ_VERDE    = 3'b001;
  localparam logic [2:0] LUZ_AMARELA  = 3'b010;
  localparam logic [2:0] LUZ_VERMELHA = 3'b100;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    PEDIDO   = 2'd1,
    ATENDIDO = 2'd2,
    BLOQUEIO = 2'd3
  } estado_t;

  // Codes that are not one-hot never count as red.
  function automatic logic eh_vermelho(input logic [2:0] luz);
    return luz == LUZ_VERMELHA;
  endfunction

endpackage

// File: rtl/botao_pedestre_debounce.sv
// debounce_botao: two-flop synchroniser and counter debouncer for the raw button.
// rise pulses for one cycle, during the cycle whose closing edge flips deb 0->1.
module debounce_botao #(
  parameter logic [7:0] DEB_CYCLES = 8'd4
) (
  input  logic clk,
  input  logic rst,
  input  logic bt_in,
  output logic rise
);

  logic       s1;
  logic       s2;
  logic       deb;
  logic [7:0] cnt;
  logic       flip;

  // deb changes only after DEB_CYCLES consecutive edges of disagreement.
  assign flip = (s2 != deb) && (cnt == DEB_CYCLES - 8'd1);
  assign rise = flip && !deb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      deb <= 1'b0;
      cnt <= 8'd0;
    end else begin
      s1 <= bt_in;
      s2 <= s1;
      if (s2 == deb) begin
        cnt <= 8'd0;
      end else if (flip) begin
        deb <= ~deb;
        cnt <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/botao_pedestre.sv
// botao_pedestre: latches one crossing request for semaforo and holds it until light A is red.
// Define BOTAO_BLOQUEIO_EN to add the HOLD_CYCLES re-arm lockout after each served request.
module botao_pedestre
  import semaforo_pkg::*;
#(
  parameter logic [7:0] DEB_CYCLES  = 8'd4,
  parameter logic [7:0] HOLD_CYCLES = 8'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt_in,
  input  logic [2:0] A,
  output logic       bt,
  output logic       pedido,
  output logic [1:0] estado
);

  estado_t estado_q;
  estado_t estado_d;
  logic    rise;
  logic    vermelho;

  debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .bt_in (bt_in),
    .rise  (rise)
  );

  // A comes registered from semaforo in this clock domain, so no synchroniser.
  assign vermelho = eh_vermelho(A);

`ifdef BOTAO_BLOQUEIO_EN
  logic [7:0] hold_cnt;
  logic       hold_fim;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= 8'd0;
    end else if (estado_q != BLOQUEIO) begin
      hold_cnt <= 8'd0;
    end else begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  assign hold_fim = (hold_cnt == HOLD_CYCLES - 8'd1);
`else
  // Without the lockout HOLD_CYCLES has no effect.
  logic unused_hold;
  assign unused_hold = ^HOLD_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q <= OCIOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Handshake: bt is a level request held from the press until the edge at which
  // A is sampled red (the acknowledge); the next request needs A to leave red first.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:   if (rise) estado_d = PEDIDO;
      PEDIDO:   if (vermelho) estado_d = ATENDIDO;
`ifdef BOTAO_BLOQUEIO_EN
      ATENDIDO: if (!vermelho) estado_d = BLOQUEIO;
      BLOQUEIO: if (hold_fim) estado_d = OCIOSO;
`else
      ATENDIDO: if (!vermelho) estado_d = OCIOSO;
      BLOQUEIO: estado_d = OCIOSO;
`endif
      default:  estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    bt     = 1'b0;
    pedido = 1'b0;
    if (estado_q == PEDIDO) begin
      bt     = 1'b1;
      pedido = 1'b1;
    end
  end

  assign estado = estado_q;

endmodule

// File: tb/tb_botao_pedestre.sv
// Bench for botao_pedestre: directed test-plan scenarios then random button/light traffic,
// all checked cycle by cycle against a behavioural model of the request rules.
module tb_botao_pedestre;

  localparam logic [7:0] DEB  = 8'd4;
  localparam logic [7:0] HOLD = 8'd10;
  localparam logic [2:0] VERDE    = 3'b001;
  localparam logic [2:0] AMARELA  = 3'b010;
  localparam logic [2:0] VERMELHA = 3'b100;

  logic       clk = 1'b0;
  logic       rst;
  logic       bt_in;
  logic [2:0] A;
  logic       bt;
  logic       pedido;
  logic [1:0] estado;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  // Model state: recent raw samples, recent synchronised samples, debounced level,
  // request pending, request served (waiting for A to leave red), lockout cycles left.
  bit samp[$];
  bit s2q[$];
  bit m_deb;
  bit m_pend;
  bit m_served;
  int m_lock;

  botao_pedestre #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clk    (clk),
    .rst    (rst),
    .bt_in  (bt_in),
    .A      (A),
    .bt     (bt),
    .pedido (pedido),
    .estado (estado)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    samp = '{1'b0, 1'b0};
    s2q.delete();
    m_deb    = 1'b0;
    m_pend   = 1'b0;
    m_served = 1'b0;
    m_lock   = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input bit b, input logic [2:0] a);
    bit s2;
    bit r;
    bit all_diff;
    // The synchronised sample seen at this edge is the raw sample from two edges back.
    s2 = samp[0];
    samp.push_back(b);
    void'(samp.pop_front());
    s2q.push_back(s2);
    if (s2q.size() > int'(DEB)) void'(s2q.pop_front());
    r = 1'b0;
    if (s2q.size() == int'(DEB)) begin
      all_diff = 1'b1;
      foreach (s2q[i]) if (s2q[i] == m_deb) all_diff = 1'b0;
      if (all_diff) begin
        m_deb = !m_deb;
        r     = m_deb;
        s2q.delete();
      end
    end
    if (m_pend) begin
      if (a == VERMELHA) begin
        m_pend   = 1'b0;
        m_served = 1'b1;
      end
    end else if (m_served) begin
      if (a != VERMELHA) begin
        m_served = 1'b0;
`ifdef BOTAO_BLOQUEIO_EN
        m_lock = int'(HOLD);
`endif
      end
    end else if (m_lock > 0) begin
      m_lock--;
    end else if (r) begin
      m_pend = 1'b1;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step(input string tag, input bit b, input logic [2:0] a);
    logic [1:0] e;
    bt_in = b;
    A     = a;
    @(posedge clk);
    if (rst) model_edge(b, a);
    exp_q.push_back({m_pend, m_pend});
    #1;
    e = exp_q.pop_front();
    chk({tag, "_bt"}, int'(bt), int'(e[1]));
    chk({tag, "_pedido"}, int'(pedido), int'(e[0]));
  endtask

  task automatic hold(input string tag, input int n, input bit b, input logic [2:0] a);
    for (int i = 0; i < n; i++) step(tag, b, a);
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_async_bt", int'(bt), 0);
    chk("rst_async_pedido", int'(pedido), 0);
  endtask

  // Serve whatever is pending and let the lockout (if any) expire.
  task automatic serve();
    hold("serve_red", 2, 1'b0, VERMELHA);
    hold("serve_green", int'(HOLD) + 8, 1'b0, VERDE);
  endtask

  function automatic logic [2:0] pick_a();
    case ($urandom_range(0, 6))
      0, 1:    return VERDE;
      2:       return AMARELA;
      3, 4:    return VERMELHA;
      5:       return 3'b000;
      default: return 3'b110;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int hi;
    bit b;
    int len;
    logic [2:0] a;

    rst   = 1'b0;
    bt_in = 1'b1;
    A     = VERDE;
    model_reset();

    // Reset held with the button pressed: outputs stay low.
    hold("rst_hold", 3, 1'b1, VERDE);
    chk("rst_bt_low", int'(bt), 0);
    chk("rst_estado", int'(estado), 0);
    rst = 1'b1;

    // Press latency from reset release.
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      step("rst_rel", 1'b1, VERDE);
      if (bt === 1'b1) lat = i;
    end
    chk("press_latency", lat, int'(DEB) + 2);

    // Handshake with the controller.
    hold("hand_green", 4, 1'b0, VERDE);
    chk("hand_green_hold", int'(bt), 1);
    hold("hand_amarela", 3, 1'b0, AMARELA);
    chk("hand_amarela_hold", int'(bt), 1);
    step("hand_red", 1'b0, VERMELHA);
    chk("hand_red_drop", int'(bt), 0);
    hold("hand_red2", 2, 1'b0, VERMELHA);
    step("hand_leave", 1'b0, VERDE);
`ifdef BOTAO_BLOQUEIO_EN
    chk("hand_bloqueio", int'(estado), 3);
    // Press inside the lockout is dropped even once debounced.
    hold("lock_press", 9, 1'b1, VERDE);
    chk("lock_press_ignored", int'(bt), 0);
    hold("lock_release", 8, 1'b0, VERDE);
    hold("lock_after", int'(DEB) + 2, 1'b1, VERDE);
    chk("after_lock_accepted", int'(bt), 1);
`else
    chk("hand_ocioso", int'(estado), 0);
    hold("quick_press", int'(DEB) + 2, 1'b1, VERDE);
    chk("quick_press_accepted", int'(bt), 1);
`endif
    serve();

    // Bounce shorter than the debounce window.
    step("bounce", 1'b1, VERDE);
    step("bounce", 1'b0, VERDE);
    step("bounce", 1'b1, VERDE);
    hold("bounce", 9, 1'b0, VERDE);
    chk("bounce_ignored", int'(bt), 0);
    hold("clean", int'(DEB) + 2, 1'b1, VERDE);
    chk("clean_press", int'(bt), 1);
    serve();

    // Press while A is already red: exactly one cycle of bt.
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      step("red_press", 1'b1, VERMELHA);
      if (bt === 1'b1) hi++;
    end
    chk("red_pulse_len", hi, 1);
    hold("red_release", 8, 1'b0, VERMELHA);
    serve();

    // Second press during PEDIDO is absorbed.
    hold("p1", int'(DEB) + 2, 1'b1, VERDE);
    hold("p1_rel", 7, 1'b0, VERDE);
    hold("p2", int'(DEB) + 3, 1'b1, VERDE);
    chk("p2_still_pedido", int'(pedido), 1);
    step("p2_red", 1'b0, VERMELHA);
    chk("p2_served", int'(bt), 0);
    hold("p2_after", int'(HOLD) + 8, 1'b0, VERDE);
    chk("p2_no_extra", int'(bt), 0);

    // Reset in the middle of a request.
    hold("mid", int'(DEB) + 2, 1'b1, VERDE);
    chk("mid_pending", int'(bt), 1);
    reset_pulse();
    step("mid_rst", 1'b0, VERDE);
    rst = 1'b1;
    hold("mid_after", 10, 1'b0, VERDE);
    chk("mid_discarded", int'(bt), 0);

    // Random traffic.
    a = VERDE;
    for (int seg = 0; seg < 400; seg++) begin
      b   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 5) == 0) a = pick_a();
        step("rand", b, a);
      end
      if ($urandom_range(0, 99) == 0) begin
        reset_pulse();
        step("rand_rst", b, a);
        rst = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
